// File: rtl/register_file.sv
// Fifteen-entry register file with two combinational read ports, one write port,
// and address 15 mapped to an externally supplied value (PC+8) that is never stored.
module register_file #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             WE3,
    input  logic [3:0]       A1,
    input  logic [3:0]       A2,
    input  logic [3:0]       A3,
    input  logic [WIDTH-1:0] WD3,
    input  logic [WIDTH-1:0] R15,
    output logic [WIDTH-1:0] RD1,
    output logic [WIDTH-1:0] RD2,
    output logic [WIDTH-1:0] R0,
    output logic [WIDTH-1:0] R1
);

    localparam int NREGS = 15;

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];

    // Address 15 never matches any slot, so writes to it fall through untouched.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            if (WE3 && (A3 == i[3:0])) begin
                regs_d[i] = WD3;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (!rst_n) begin
                regs_q[i] <= '0;
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    function automatic logic [WIDTH-1:0] read_port(
        input logic [3:0]       addr,
        input logic [WIDTH-1:0] pc_val
    );
        logic [WIDTH-1:0] val;
        val = pc_val;
        for (int i = 0; i < NREGS; i++) begin
            if (addr == i[3:0]) begin
                val = regs_q[i];
            end
        end
        return val;
    endfunction

    assign RD1 = read_port(A1, R15);
    assign RD2 = read_port(A2, R15);
    assign R0  = regs_q[0];
    assign R1  = regs_q[1];

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios followed by random
// traffic compared against an array-based reference model.
module tb_register_file;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             WE3;
    logic [3:0]       A1, A2, A3;
    logic [WIDTH-1:0] WD3, R15;
    logic [WIDTH-1:0] RD1, RD2, R0, R1;

    int checks;
    int failures;

    logic [WIDTH-1:0] model [15];

    register_file #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .WE3   (WE3),
        .A1    (A1),
        .A2    (A2),
        .A3    (A3),
        .WD3   (WD3),
        .R15   (R15),
        .RD1   (RD1),
        .RD2   (RD2),
        .R0    (R0),
        .R1    (R1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [WIDTH-1:0] obs,
                             input logic [WIDTH-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] model_read(input logic [3:0] a);
        if (a == 4'd15) return R15;
        return model[a];
    endfunction

    // Model the effect of the upcoming edge from the inputs currently applied.
    task automatic do_edge();
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) model[i] = '0;
        end else if (WE3 && A3 != 4'd15) begin
            model[A3] = WD3;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".RD1"}, RD1, model_read(A1));
        check_val({tag, ".RD2"}, RD2, model_read(A2));
        check_val({tag, ".R0"},  R0,  model[0]);
        check_val({tag, ".R1"},  R1,  model[1]);
    endtask

    task automatic set_in(input logic we, input logic [3:0] a1, input logic [3:0] a2,
                          input logic [3:0] a3, input logic [WIDTH-1:0] wd);
        WE3 = we; A1 = a1; A2 = a2; A3 = a3; WD3 = wd;
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 15; i++) model[i] = 'x;
        rst_n = 1'b0; WE3 = 1'b1; A1 = 0; A2 = 0; A3 = 4'd3; WD3 = 32'hDEAD_BEEF;
        R15 = 32'h0;
        #2;
        do_edge();
        rst_n = 1'b1;

        // Reset state
        set_in(1'b0, 4'd0, 4'd1, 4'd0, '0);
        check_val("rst_rd1_a0", RD1, 32'd0);
        check_val("rst_rd2_a1", RD2, 32'd0);
        check_val("rst_r0", R0, 32'd0);
        check_val("rst_r1", R1, 32'd0);
        set_in(1'b0, 4'd2, 4'd3, 4'd0, '0);
        check_val("rst_rd1_a2", RD1, 32'd0);
        check_val("rst_rd2_a3", RD2, 32'd0);
        check_val("rst_wr3_dropped", RD2, model_read(4'd3));

        // Write latency, no bypass
        set_in(1'b1, 4'd2, 4'd0, 4'd2, 32'd100);
        check_val("wr2_before", RD1, 32'd0);
        do_edge();
        check_val("wr2_after", RD1, 32'd100);
        check_val("wr2_rd2_a0", RD2, 32'd0);

        // Register 0 and R0 output
        set_in(1'b1, 4'd0, 4'd2, 4'd0, 32'd256);
        do_edge();
        check_val("wr0_rd1", RD1, 32'd256);
        check_val("wr0_r0", R0, 32'd256);
        check_val("wr0_r1", R1, 32'd0);

        // Address 15 reads R15, writes ignored
        R15 = 32'h1234;
        set_in(1'b0, 4'd15, 4'd15, 4'd0, '0);
        check_val("r15_rd1", RD1, 32'h1234);
        check_val("r15_rd2", RD2, 32'h1234);
        set_in(1'b1, 4'd15, 4'd15, 4'd15, 32'd7);
        do_edge();
        check_val("wr15_rd1", RD1, 32'h1234);
        for (int i = 0; i < 15; i++) begin
            set_in(1'b0, i[3:0], i[3:0], 4'd0, '0);
            check_val($sformatf("wr15_keep%0d", i), RD1, model[i]);
        end

        // Write enable gating
        set_in(1'b0, 4'd5, 4'd5, 4'd5, 32'hFFFF_FFFF);
        do_edge();
        check_val("we0_a5", RD1, 32'd0);
        set_in(1'b1, 4'd5, 4'd5, 4'd5, 32'hFFFF_FFFF);
        do_edge();
        check_val("we1_a5", RD1, 32'hFFFF_FFFF);

        // Reset overrides a concurrent write
        set_in(1'b1, 4'd1, 4'd0, 4'd1, 32'd9);
        do_edge();
        check_val("pre_r1", R1, 32'd9);
        rst_n = 1'b0;
        set_in(1'b1, 4'd1, 4'd5, 4'd1, 32'd55);
        check_val("rst_nonasync_r1", R1, 32'd9);
        do_edge();
        rst_n = 1'b1;
        #1;
        check_val("rst_wr_r1", R1, 32'd0);
        check_val("rst_wr_a5", RD2, 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            R15   = $urandom;
            set_in($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom),
                   4'($urandom), $urandom);
            check_all($sformatf("rnd%0d_pre", n));
            do_edge();
            check_all($sformatf("rnd%0d_post", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
